// File: rtl/run_blob_stats.sv
`default_nettype none
// ============================================================================
// run_blob_stats : per-frame single-blob statistics from run-length FIFO words
// Revision       : 1.0
// ============================================================================
module run_blob_stats #(
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int CNT_W     = 20,
    parameter int SUM_W     = 30,
    parameter int MIN_COUNT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             empty,
    input  logic [2*X_W:0]   dout,
    output logic             rd_en,
    output logic             frame_valid,
    output logic             found,
    output logic [CNT_W-1:0] pixel_count,
    output logic [X_W-1:0]   centroid_x,
    output logic [Y_W-1:0]   centroid_y,
    output logic [X_W-1:0]   bbox_x_min,
    output logic [X_W-1:0]   bbox_x_max,
    output logic [Y_W-1:0]   bbox_y_min,
    output logic [Y_W-1:0]   bbox_y_max
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DIV_X = 3'd2,
        S_DIV_Y = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int c_div_cw = $clog2(SUM_W);
    localparam logic [c_div_cw-1:0] c_div_last = c_div_cw'(SUM_W - 1);
    localparam int c_xp_w = 2 * X_W + 1;
    localparam int c_yp_w = Y_W + X_W + 1;

    state_t              state_q, state_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SUM_W-1:0]    sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [X_W-1:0]      x_min_q, x_min_d, x_max_q, x_max_d;
    logic [Y_W-1:0]      y_min_q, y_min_d, y_max_q, y_max_d;
    logic [CNT_W-1:0]    lat_count_q, lat_count_d;
    logic [SUM_W-1:0]    lat_sum_y_q, lat_sum_y_d;
    logic [X_W-1:0]      lat_x_min_q, lat_x_min_d, lat_x_max_q, lat_x_max_d;
    logic [Y_W-1:0]      lat_y_min_q, lat_y_min_d, lat_y_max_q, lat_y_max_d;
    logic                skip_q, skip_d;
    logic [SUM_W-1:0]    div_num_q, div_num_d, div_rem_q, div_rem_d;
    logic [c_div_cw-1:0] div_cnt_q, div_cnt_d;
    logic [X_W-1:0]      quo_x_q, quo_x_d;
    logic                frame_valid_q, frame_valid_d, found_q, found_d;
    logic [CNT_W-1:0]    pixel_count_q, pixel_count_d;
    logic [X_W-1:0]      centroid_x_q, centroid_x_d;
    logic [Y_W-1:0]      centroid_y_q, centroid_y_d;
    logic [X_W-1:0]      bbox_x_min_q, bbox_x_min_d, bbox_x_max_q, bbox_x_max_d;
    logic [Y_W-1:0]      bbox_y_min_q, bbox_y_min_d, bbox_y_max_q, bbox_y_max_d;

    logic              w_cmd;
    logic [X_W-1:0]    w_start, w_end;
    logic [X_W:0]      w_len;
    logic [c_xp_w-1:0] w_xprod;
    logic [c_yp_w-1:0] w_yprod;
    logic [SUM_W-1:0]  w_x_add, w_y_add;
    logic              w_skip;
    logic [SUM_W:0]    w_rem_sh, w_diff;
    logic              w_ge;
    logic [SUM_W-1:0]  w_num_nx, w_rem_nx;

    assign w_cmd   = dout[2*X_W];
    assign w_start = dout[2*X_W-1:X_W];
    assign w_end   = dout[X_W-1:0];
    assign w_len   = {1'b0, w_end} - {1'b0, w_start} + (X_W+1)'(1);

    // (start+end)*len is always even, so the halving is exact
    assign w_xprod = (c_xp_w'(w_start) + c_xp_w'(w_end)) * c_xp_w'(w_len);
    assign w_x_add = SUM_W'(w_xprod >> 1);
    assign w_yprod = c_yp_w'(y_q) * c_yp_w'(w_len);
    assign w_y_add = SUM_W'(w_yprod);
    assign w_skip  = (count_q == '0) || (count_q < CNT_W'(MIN_COUNT));

    // Restoring divide step; a borrow out of the subtract means no quotient bit
    assign w_rem_sh = {div_rem_q, div_num_q[SUM_W-1]};
    assign w_diff   = w_rem_sh - (SUM_W+1)'(lat_count_q);
    assign w_ge     = !w_diff[SUM_W];
    assign w_rem_nx = w_ge ? w_diff[SUM_W-1:0] : w_rem_sh[SUM_W-1:0];
    assign w_num_nx = {div_num_q[SUM_W-2:0], w_ge};

    assign rd_en = (state_q == S_IDLE) && !empty && !rst;

    always_comb begin
        state_d       = state_q;
        y_d           = y_q;
        count_d       = count_q;
        sum_x_d       = sum_x_q;
        sum_y_d       = sum_y_q;
        x_min_d       = x_min_q;
        x_max_d       = x_max_q;
        y_min_d       = y_min_q;
        y_max_d       = y_max_q;
        lat_count_d   = lat_count_q;
        lat_sum_y_d   = lat_sum_y_q;
        lat_x_min_d   = lat_x_min_q;
        lat_x_max_d   = lat_x_max_q;
        lat_y_min_d   = lat_y_min_q;
        lat_y_max_d   = lat_y_max_q;
        skip_d        = skip_q;
        div_num_d     = div_num_q;
        div_rem_d     = div_rem_q;
        div_cnt_d     = div_cnt_q;
        quo_x_d       = quo_x_q;
        frame_valid_d = 1'b0;
        found_d       = found_q;
        pixel_count_d = pixel_count_q;
        centroid_x_d  = centroid_x_q;
        centroid_y_d  = centroid_y_q;
        bbox_x_min_d  = bbox_x_min_q;
        bbox_x_max_d  = bbox_x_max_q;
        bbox_y_min_d  = bbox_y_min_q;
        bbox_y_max_d  = bbox_y_max_q;

        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_IDLE;
                if (!w_cmd) begin
                    if (w_end >= w_start) begin
                        count_d = count_q + CNT_W'(w_len);
                        sum_x_d = sum_x_q + w_x_add;
                        sum_y_d = sum_y_q + w_y_add;
                        if (w_start < x_min_q) x_min_d = w_start;
                        if (w_end > x_max_q)   x_max_d = w_end;
                        if (y_q < y_min_q)     y_min_d = y_q;
                        if (y_q > y_max_q)     y_max_d = y_q;
                    end
                end else begin
                    if (w_start[0] && (y_q != '1)) y_d = y_q + Y_W'(1);
                    if (w_start[1]) begin
                        lat_count_d = count_q;
                        lat_sum_y_d = sum_y_q;
                        lat_x_min_d = x_min_q;
                        lat_x_max_d = x_max_q;
                        lat_y_min_d = y_min_q;
                        lat_y_max_d = y_max_q;
                        skip_d      = w_skip;
                        div_num_d   = sum_x_q;
                        div_rem_d   = '0;
                        div_cnt_d   = '0;
                        count_d     = '0;
                        sum_x_d     = '0;
                        sum_y_d     = '0;
                        y_d         = '0;
                        x_min_d     = '1;
                        x_max_d     = '0;
                        y_min_d     = '1;
                        y_max_d     = '0;
                        state_d     = S_DIV_X;
                    end
                end
            end
            S_DIV_X: begin
                div_num_d = w_num_nx;
                div_rem_d = w_rem_nx;
                div_cnt_d = div_cnt_q + c_div_cw'(1);
                if (div_cnt_q == c_div_last) begin
                    quo_x_d   = skip_q ? '0 : w_num_nx[X_W-1:0];
                    div_num_d = lat_sum_y_q;
                    div_rem_d = '0;
                    div_cnt_d = '0;
                    state_d   = S_DIV_Y;
                end
            end
            S_DIV_Y: begin
                div_num_d = w_num_nx;
                div_rem_d = w_rem_nx;
                div_cnt_d = div_cnt_q + c_div_cw'(1);
                if (div_cnt_q == c_div_last) begin
                    frame_valid_d = 1'b1;
                    found_d       = !skip_q;
                    pixel_count_d = lat_count_q;
                    centroid_x_d  = quo_x_q;
                    centroid_y_d  = skip_q ? '0 : w_num_nx[Y_W-1:0];
                    bbox_x_min_d  = skip_q ? '0 : lat_x_min_q;
                    bbox_x_max_d  = skip_q ? '0 : lat_x_max_q;
                    bbox_y_min_d  = skip_q ? '0 : lat_y_min_q;
                    bbox_y_max_d  = skip_q ? '0 : lat_y_max_q;
                    state_d       = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            y_q           <= '0;
            count_q       <= '0;
            sum_x_q       <= '0;
            sum_y_q       <= '0;
            x_min_q       <= '1;
            x_max_q       <= '0;
            y_min_q       <= '1;
            y_max_q       <= '0;
            lat_count_q   <= '0;
            lat_sum_y_q   <= '0;
            lat_x_min_q   <= '0;
            lat_x_max_q   <= '0;
            lat_y_min_q   <= '0;
            lat_y_max_q   <= '0;
            skip_q        <= 1'b1;
            div_num_q     <= '0;
            div_rem_q     <= '0;
            div_cnt_q     <= '0;
            quo_x_q       <= '0;
            frame_valid_q <= 1'b0;
            found_q       <= 1'b0;
            pixel_count_q <= '0;
            centroid_x_q  <= '0;
            centroid_y_q  <= '0;
            bbox_x_min_q  <= '0;
            bbox_x_max_q  <= '0;
            bbox_y_min_q  <= '0;
            bbox_y_max_q  <= '0;
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            count_q       <= count_d;
            sum_x_q       <= sum_x_d;
            sum_y_q       <= sum_y_d;
            x_min_q       <= x_min_d;
            x_max_q       <= x_max_d;
            y_min_q       <= y_min_d;
            y_max_q       <= y_max_d;
            lat_count_q   <= lat_count_d;
            lat_sum_y_q   <= lat_sum_y_d;
            lat_x_min_q   <= lat_x_min_d;
            lat_x_max_q   <= lat_x_max_d;
            lat_y_min_q   <= lat_y_min_d;
            lat_y_max_q   <= lat_y_max_d;
            skip_q        <= skip_d;
            div_num_q     <= div_num_d;
            div_rem_q     <= div_rem_d;
            div_cnt_q     <= div_cnt_d;
            quo_x_q       <= quo_x_d;
            frame_valid_q <= frame_valid_d;
            found_q       <= found_d;
            pixel_count_q <= pixel_count_d;
            centroid_x_q  <= centroid_x_d;
            centroid_y_q  <= centroid_y_d;
            bbox_x_min_q  <= bbox_x_min_d;
            bbox_x_max_q  <= bbox_x_max_d;
            bbox_y_min_q  <= bbox_y_min_d;
            bbox_y_max_q  <= bbox_y_max_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign found       = found_q;
    assign pixel_count = pixel_count_q;
    assign centroid_x  = centroid_x_q;
    assign centroid_y  = centroid_y_q;
    assign bbox_x_min  = bbox_x_min_q;
    assign bbox_x_max  = bbox_x_max_q;
    assign bbox_y_min  = bbox_y_min_q;
    assign bbox_y_max  = bbox_y_max_q;

endmodule
`default_nettype wire

// File: tb/tb_run_blob_stats.sv
`default_nettype none
// ============================================================================
// tb_run_blob_stats : directed frames through a queue-backed FIFO; expected
//                     statistics are recomputed pixel by pixel from popped runs
// Revision          : 1.0
// ============================================================================
module tb_run_blob_stats;
    localparam int X_W = 10, Y_W = 10, CNT_W = 20, SUM_W = 30, MIN_COUNT = 16;
    localparam int LAT = 2 * SUM_W + 1;

    typedef logic [2*X_W:0] word_t;
    typedef struct { int s; int e; int y; } run_t;
    typedef struct { int cnt; int cx; int cy; int xmin; int xmax; int ymin; int ymax; bit fnd; int t; } exp_t;

    logic clk = 1'b0, rst, empty, empty1;
    word_t dout, dout1;
    logic rd_en, frame_valid, found, rd_en1, frame_valid1, found1;
    logic [CNT_W-1:0] pixel_count, pixel_count1;
    logic [X_W-1:0] centroid_x, bbox_x_min, bbox_x_max, centroid_x1, bbox_x_min1, bbox_x_max1;
    logic [Y_W-1:0] centroid_y, bbox_y_min, bbox_y_max, centroid_y1, bbox_y_min1, bbox_y_max1;

    run_blob_stats #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .SUM_W(SUM_W), .MIN_COUNT(MIN_COUNT)) u_dut (
        .clk(clk), .rst(rst), .empty(empty), .dout(dout), .rd_en(rd_en),
        .frame_valid(frame_valid), .found(found), .pixel_count(pixel_count),
        .centroid_x(centroid_x), .centroid_y(centroid_y),
        .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max));

    run_blob_stats #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .SUM_W(SUM_W), .MIN_COUNT(1)) u_dut1 (
        .clk(clk), .rst(rst), .empty(empty1), .dout(dout1), .rd_en(rd_en1),
        .frame_valid(frame_valid1), .found(found1), .pixel_count(pixel_count1),
        .centroid_x(centroid_x1), .centroid_y(centroid_y1),
        .bbox_x_min(bbox_x_min1), .bbox_x_max(bbox_x_max1),
        .bbox_y_min(bbox_y_min1), .bbox_y_max(bbox_y_max1));

    always #5 clk = ~clk;

    word_t fifo_q[$], fifo1_q[$], pw;
    run_t  runs[$];
    exp_t  exp_q[$];
    exp_t  last;
    int    m_y = 0, cyc = 0, n_checks = 0, n_fail = 0;
    bit    hold = 0, rnd_mode = 0, prev_rd = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic word_t run_w(input int s, input int e);
        return {1'b0, X_W'(s), X_W'(e)};
    endfunction

    function automatic word_t ctl_w(input int bits);
        return {1'b1, X_W'(bits), X_W'(0)};
    endfunction

    // Statistics of the current frame from first principles: walk every pixel.
    function automatic exp_t frame_stats(input int t);
        exp_t r;
        longint sx = 0, sy = 0;
        int xmn = 1 << 30, xmx = -1, ymn = 1 << 30, ymx = -1;
        r = '{default: 0};
        foreach (runs[i]) begin
            for (int x = runs[i].s; x <= runs[i].e; x++) begin
                r.cnt++;
                sx += x;
                sy += runs[i].y;
                if (x < xmn) xmn = x;
                if (x > xmx) xmx = x;
                if (runs[i].y < ymn) ymn = runs[i].y;
                if (runs[i].y > ymx) ymx = runs[i].y;
            end
        end
        r.fnd = (r.cnt >= MIN_COUNT);
        if (r.fnd) begin
            r.cx = int'(sx / r.cnt);
            r.cy = int'(sy / r.cnt);
            r.xmin = xmn; r.xmax = xmx; r.ymin = ymn; r.ymax = ymx;
        end
        r.t = t;
        return r;
    endfunction

    task automatic model_word(input word_t w);
        int s, e;
        s = int'(w[2*X_W-1:X_W]);
        e = int'(w[X_W-1:0]);
        if (!w[2*X_W]) begin
            if (e >= s) runs.push_back('{s, e, m_y});
        end else begin
            if (s[0]) m_y = (m_y < (1 << Y_W) - 1) ? m_y + 1 : m_y;
            if (s[1]) begin
                exp_q.push_back(frame_stats(cyc + 1 + LAT));
                runs.delete();
                m_y = 0;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: one-cycle read latency
    always @(posedge clk) begin
        if (rst) begin
            runs.delete();
            m_y = 0;
        end else if (rd_en) begin
            if (fifo_q.size() == 0) chk("pop_from_empty_fifo", 1, 0);
            else begin
                pw = fifo_q.pop_front();
                dout <= pw;
                model_word(pw);
            end
        end
        if (rd_en1 && fifo1_q.size() != 0) dout1 <= fifo1_q.pop_front();
    end

    always @(posedge clk) begin
        #2;
        empty  = (fifo_q.size() == 0) || hold || (rnd_mode && ($urandom_range(0, 1) == 1));
        empty1 = (fifo1_q.size() == 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last = '{default: 0};
            chk("rd_en_in_reset", rd_en, 0);
        end else begin
            chk("rd_en_while_empty", rd_en && empty, 0);
            chk("rd_en_back_to_back", rd_en && prev_rd, 0);
            if (frame_valid) begin
                if (exp_q.size() == 0) chk("unexpected_frame_valid", 1, 0);
                else begin
                    last = exp_q.pop_front();
                    chk("frame_valid_cycle", cyc, last.t);
                end
            end else if (exp_q.size() != 0 && cyc >= exp_q[0].t) begin
                chk("frame_valid_missing", 0, 1);
                last = exp_q.pop_front();
            end
            chk("found", found, last.fnd);
            chk("pixel_count", pixel_count, last.cnt);
            chk("centroid_x", centroid_x, last.cx);
            chk("centroid_y", centroid_y, last.cy);
            chk("bbox_x_min", bbox_x_min, last.xmin);
            chk("bbox_x_max", bbox_x_max, last.xmax);
            chk("bbox_y_min", bbox_y_min, last.ymin);
            chk("bbox_y_max", bbox_y_max, last.ymax);
        end
        prev_rd = rd_en;
    end

    task automatic push(input word_t w);
        fifo_q.push_back(w);
    endtask

    task automatic frame_a(input bit bad);
        for (int l = 0; l < 5; l++) begin
            push(run_w(5, 18));
            if (bad && l == 2) push(run_w(20, 10));
            push(run_w(24, 28));
            push(ctl_w(1));
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain_timeout"}, (n >= 6000) ? 1 : 0, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_a(input string name);
        chk({name, "_pixel_count"}, pixel_count, 95);
        chk({name, "_found"}, found, 1);
        chk({name, "_centroid_x"}, centroid_x, 15);
        chk({name, "_centroid_y"}, centroid_y, 2);
        chk({name, "_bbox_x"}, {bbox_x_min, bbox_x_max}, {10'd5, 10'd28});
        chk({name, "_bbox_y"}, {bbox_y_min, bbox_y_max}, {10'd0, 10'd4});
    endtask

    initial begin
        int n;
        rst = 1'b1; empty = 1'b1; empty1 = 1'b1; dout = '0; dout1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_pixel_count", pixel_count, 0);
        chk("reset_frame_valid", frame_valid, 0);

        frame_a(0); push(ctl_w(2));
        wait_drain("frame_a");
        chk_a("frame_a");

        push(ctl_w(2));
        wait_drain("empty_frame");
        chk("empty_frame_pixel_count", pixel_count, 0);
        chk("empty_frame_found", found, 0);

        frame_a(1); push(ctl_w(2));
        wait_drain("malformed");
        chk_a("malformed");

        push(run_w(100, 114)); push(ctl_w(2));
        wait_drain("count15");
        chk("count15_found", found, 0);
        chk("count15_pixel_count", pixel_count, 15);
        chk("count15_bbox_x_max", bbox_x_max, 0);
        push(run_w(100, 115)); push(ctl_w(2));
        wait_drain("count16");
        chk("count16_found", found, 1);
        chk("count16_centroid_x", centroid_x, 107);

        push(run_w(0, 9)); push(ctl_w(1)); push(run_w(10, 19)); push(ctl_w(3));
        push(run_w(50, 69)); push(ctl_w(2));
        wait_drain("both_bits");

        push(run_w(5, 18)); push(run_w(24, 28)); push(ctl_w(1));
        push(run_w(5, 18)); push(run_w(24, 28)); push(ctl_w(1));
        n = 0;
        while (fifo_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        hold = 1'b1;
        for (int l = 2; l < 5; l++) begin
            push(run_w(5, 18)); push(run_w(24, 28)); push(ctl_w(1));
        end
        push(ctl_w(2));
        repeat (50) @(negedge clk);
        chk("stall_fifo_untouched", fifo_q.size(), 10);
        hold = 1'b0;
        wait_drain("stall");
        chk_a("stall");

        rnd_mode = 1'b1;
        frame_a(0); push(ctl_w(2));
        wait_drain("random_empty");
        rnd_mode = 1'b0;
        chk_a("random_empty");

        for (int i = 0; i < 1030; i++) push(ctl_w(1));
        push(run_w(0, 15)); push(ctl_w(2));
        wait_drain("y_saturate");
        chk("y_saturate_centroid_y", centroid_y, 1023);

        frame_a(0); push(ctl_w(2));
        n = 0;
        while (exp_q.size() == 0 && n < 200) begin @(negedge clk); n++; end
        chk("reset_test_end_frame_seen", exp_q.size(), 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("after_reset_pixel_count", pixel_count, 0);
        chk("after_reset_found", found, 0);
        frame_a(0); push(ctl_w(2));
        wait_drain("after_reset");
        chk_a("after_reset");

        fifo1_q.push_back(run_w(639, 639));
        fifo1_q.push_back(ctl_w(2));
        n = 0;
        while (!frame_valid1 && n < 300) begin @(negedge clk); n++; end
        chk("min1_frame_valid", frame_valid1, 1);
        chk("min1_pixel_count", pixel_count1, 1);
        chk("min1_found", found1, 1);
        chk("min1_centroid_x", centroid_x1, 639);
        chk("min1_centroid_y", centroid_y1, 0);
        chk("min1_bbox_x", {bbox_x_min1, bbox_x_max1}, {10'd639, 10'd639});
        chk("min1_bbox_y", {bbox_y_min1, bbox_y_max1}, {10'd0, 10'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/run_blob_stats.md
# run_blob_stats

Downstream consumer of `run_fifo_manager`: pops run and control words from the run FIFO and accumulates single-object statistics per frame. Tracked per frame: pixel count, x/y sums and bounding box. At end of frame, a sequential divider computes the integer centroid and presents one result set with a single-cycle `frame_valid` pulse. Its outputs feed the hexapod's target-tracking logic.

## Interface
Parameters:
- `X_W`, 10: column width; must equal the FIFO start/end field width.
- `Y_W`, 10: line counter width.
- `CNT_W`, 20: pixel-count accumulator width.
- `SUM_W`, 30: x-sum and y-sum accumulator width, and divider width.
- `MIN_COUNT`, 16: minimum pixel count for `found`.

Ports:
- `clk` in 1: single clock. Synchronous, active-high reset, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `empty` in 1: run FIFO empty flag.
- `dout` in 1+2·X_W: FIFO word `{cmd, start, end}`.
- `rd_en` out 1: FIFO pop request.
- `frame_valid` out 1: one-cycle pulse; result outputs updated in the same cycle.
- `found` out 1: `pixel_count >= MIN_COUNT`.
- `pixel_count` out CNT_W: total set pixels in the frame.
- `centroid_x` out X_W: `floor(sum_x / count)`.
- `centroid_y` out Y_W: `floor(sum_y / count)`.
- `bbox_x_min`, `bbox_x_max` out X_W each: horizontal bounding box.
- `bbox_y_min`, `bbox_y_max` out Y_W each: vertical bounding box.

## Operation
- Word decode:
  - `cmd=0` is a run. `start`/`end` are inclusive columns; `len = end-start+1`.
  - `cmd=1` is a control word. `start[0]` means end_line; `start[1]` means end_frame. Both bits set: end_line is applied first, then end_frame.
- Run with `end < start`: malformed; the word is consumed and discarded, with no state change.
- Per valid run:
  - `count += len`
  - `sum_x += (start+end)*len/2`. The product is always even and is computed at 2·X_W+1 bits before the shift.
  - `sum_y += y*len`
  - `x_min = min(x_min,start)`, `x_max = max(x_max,end)`
  - `y_min = min(y_min,y)`, `y_max = max(y_max,y)`
- end_line: `y <= y+1`, saturating at `2^Y_W-1`. Line 0 is the line before the first end_line of a frame.
- end_frame sequence:
  - Latch the accumulators into the divider.
  - Clear the accumulators, set `y=0`, reset min registers to all-ones and max registers to 0.
  - Run the divides.
- States:
  - IDLE: if `!empty`, assert `rd_en` for one cycle and go to FETCH.
  - FETCH: `dout` is valid this cycle. Process the word. Return to IDLE, or go to DIV_X on end_frame.
  - DIV_X: restoring divide `sum_x/count`, SUM_W cycles, one quotient bit per cycle.
  - DIV_Y: same for `sum_y/count`, SUM_W cycles.
  - DONE: register the outputs, pulse `frame_valid`, return to IDLE.
- Quotients are truncated to X_W / Y_W bits. A valid frame never exceeds these.
- `count == 0`, or `count < MIN_COUNT`:
  - Divides are skipped (DIV_X/DIV_Y still take their cycles; the quotient is forced to 0).
  - `found=0`; centroid and bbox outputs are 0; `pixel_count` still reports the true count.
- `rd_en` is held low in DIV_X, DIV_Y and DONE. The FIFO absorbs backpressure.
- Result outputs hold their values until the next DONE.

## Timing
- Reset: `rd_en=0`, `frame_valid=0`, all result outputs 0, state IDLE, `y=0`, accumulators 0. A mid-frame or mid-divide reset discards partial data; no `frame_valid` is issued for that frame.
- FIFO read latency is 1: `rd_en` is high in cycle N and `dout` is sampled in cycle N+1.
- Throughput: one word per 2 cycles maximum.
- `rd_en` is never asserted while `empty=1`, and never on two consecutive cycles.
- end_frame word sampled in cycle T: DIV_X spans T+1..T+SUM_W, DIV_Y spans T+SUM_W+1..T+2·SUM_W, and `frame_valid` is high in T+2·SUM_W+1. That is cycle T+61 at the defaults.
- Next `rd_en` is no earlier than T+2·SUM_W+2.

## Test plan
- Frame of 5 lines, each with runs [5,18] and [24,28], then end_line. End_frame follows -> `frame_valid` once with:
  - `pixel_count=95`, `found=1`
  - `centroid_x=15` (1455/95), `centroid_y=2` (190/95)
  - bbox x 5..28, y 0..4
- End_frame with no runs -> `frame_valid` 61 cycles after the sampled word. `found=0`, `pixel_count=0`, all other outputs 0.
- `MIN_COUNT=1`, single run [639,639] on line 0, then end_frame -> `pixel_count=1`, `centroid_x=639`, `centroid_y=0`, bbox x 639..639, y 0..0.
- Malformed run [20,10] injected among valid runs -> statistics identical to the same frame without it; the word is still popped.
- FIFO held empty for 50 cycles mid-frame, plus a random empty pattern -> `rd_en` never high with `empty=1` and never on consecutive cycles; results unchanged.
- `rst` pulsed during DIV_X -> no `frame_valid`, outputs 0. The following clean frame produces correct results.
